// File: rtl/vga_timing_gen.sv
// Purpose : free-running 640x480@60 VGA raster timing: scan coordinates,
//           visible-region flag, delayed active-low syncs, line/frame strobes.
// Latency : DrawX/DrawY/blank/line_start/frame_start registered together;
//           hs/vs trail the coordinates they describe by SYNC_DELAY cycles.
// Backpressure: none, the raster free-runs on every vga_clk edge.
//
// Ports:
//   vga_clk     in   1  pixel clock, all state on posedge
//   reset       in   1  asynchronous, active-high
//   DrawX       out 10  horizontal count, 0..H_TOTAL-1
//   DrawY       out 10  vertical count, 0..V_TOTAL-1
//   blank       out  1  1 = visible pixel, 0 = blanking interval
//   hs, vs      out  1  active-low syncs, delayed SYNC_DELAY cycles
//   line_start  out  1  high while DrawX==0
//   frame_start out  1  high while DrawX==0 and DrawY==0
//   frame_count out  8  frames completed since reset, wraps 255->0
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must fit a 10-bit counter");
  end
  if (SYNC_DELAY < 0 || SYNC_DELAY > 3) begin : g_bad_delay
    $error("vga_timing_gen: SYNC_DELAY must be 0..3");
  end

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // 11-bit bounds so a region ending exactly at 1024 still compares correctly.
  localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START   = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FP + V_SYNC);

  // The first edge after reset only loads position (0,0) into the outputs;
  // counting starts on the edge after that, so that cycle shows the origin.
  logic       run;

  logic [9:0] hc_nxt;
  logic [9:0] vc_nxt;
  logic [7:0] fc_nxt;
  logic [10:0] hc_ext;
  logic [10:0] vc_ext;
  logic       hs_raw;
  logic       vs_raw;

  // Stage 0 is registered alongside DrawX/DrawY; stages 1..SYNC_DELAY add
  // the alignment delay for the renderers' registered colour path.
  logic [SYNC_DELAY:0] hs_pipe;
  logic [SYNC_DELAY:0] vs_pipe;

  always_comb begin
    hc_nxt = DrawX;
    vc_nxt = DrawY;
    fc_nxt = frame_count;
    if (!run) begin
      hc_nxt = 10'd0;
      vc_nxt = 10'd0;
    end else if (DrawX == H_LAST) begin
      hc_nxt = 10'd0;
      if (DrawY == V_LAST) begin
        vc_nxt = 10'd0;
        fc_nxt = frame_count + 8'd1;
      end else begin
        vc_nxt = DrawY + 10'd1;
      end
    end else begin
      hc_nxt = DrawX + 10'd1;
    end
  end

  // Flags are decoded from the next position so they land in the same
  // cycle as the coordinates they describe.
  always_comb begin
    hc_ext = {1'b0, hc_nxt};
    vc_ext = {1'b0, vc_nxt};
    hs_raw = !((hc_ext >= HS_START) && (hc_ext < HS_END));
    vs_raw = !((vc_ext >= VS_START) && (vc_ext < VS_END));
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      run         <= 1'b0;
      DrawX       <= 10'd0;
      DrawY       <= 10'd0;
      blank       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      run         <= 1'b1;
      DrawX       <= hc_nxt;
      DrawY       <= vc_nxt;
      blank       <= (hc_ext < H_VIS_END) && (vc_ext < V_VIS_END);
      line_start  <= (hc_nxt == 10'd0);
      frame_start <= (hc_nxt == 10'd0) && (vc_nxt == 10'd0);
      frame_count <= fc_nxt;
    end
  end

  // Whole pipeline presets to idle-high so no partial pulse survives reset.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hs_pipe <= '1;
      vs_pipe <= '1;
    end else begin
      hs_pipe[0] <= hs_raw;
      vs_pipe[0] <= vs_raw;
      for (int i = 1; i <= SYNC_DELAY; i++) begin
        hs_pipe[i] <= hs_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
      end
    end
  end

  assign hs = hs_pipe[SYNC_DELAY];
  assign vs = vs_pipe[SYNC_DELAY];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one full-size instance plus three small-raster
// instances (SYNC_DELAY 0, 1, 3) so whole frames and the 256-frame wrap are
// reachable; every cycle is compared with a time-based reference model.
module tb_vga_timing_gen;

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;
  always #5 vga_clk = ~vga_clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  typedef struct {
    int hv, hfp, hsw, hbp, vv, vfp, vsw, vbp, d;
  } cfg_t;

  typedef struct {
    int   t;
    obs_t e;
  } vec_t;

  // Small raster: H_TOTAL = 15, V_TOTAL = 9, frame = 135 cycles.
  localparam int SHV = 8, SHFP = 2, SHSW = 3, SHBP = 2;
  localparam int SVV = 5, SVFP = 1, SVSW = 2, SVBP = 1;
  localparam int SFRAME = 135;

  logic [9:0] dx [4];
  logic [9:0] dy [4];
  logic       bl [4];
  logic       hsy[4];
  logic       vsy[4];
  logic       ls [4];
  logic       fs [4];
  logic [7:0] fc [4];
  obs_t       got[4];

  vga_timing_gen u_def (
    .vga_clk(vga_clk), .reset(reset), .DrawX(dx[0]), .DrawY(dy[0]), .blank(bl[0]),
    .hs(hsy[0]), .vs(vsy[0]), .line_start(ls[0]), .frame_start(fs[0]), .frame_count(fc[0]));

  vga_timing_gen #(.H_VISIBLE(SHV), .H_FP(SHFP), .H_SYNC(SHSW), .H_BP(SHBP),
                   .V_VISIBLE(SVV), .V_FP(SVFP), .V_SYNC(SVSW), .V_BP(SVBP),
                   .SYNC_DELAY(1)) u_s1 (
    .vga_clk(vga_clk), .reset(reset), .DrawX(dx[1]), .DrawY(dy[1]), .blank(bl[1]),
    .hs(hsy[1]), .vs(vsy[1]), .line_start(ls[1]), .frame_start(fs[1]), .frame_count(fc[1]));

  vga_timing_gen #(.H_VISIBLE(SHV), .H_FP(SHFP), .H_SYNC(SHSW), .H_BP(SHBP),
                   .V_VISIBLE(SVV), .V_FP(SVFP), .V_SYNC(SVSW), .V_BP(SVBP),
                   .SYNC_DELAY(0)) u_s0 (
    .vga_clk(vga_clk), .reset(reset), .DrawX(dx[2]), .DrawY(dy[2]), .blank(bl[2]),
    .hs(hsy[2]), .vs(vsy[2]), .line_start(ls[2]), .frame_start(fs[2]), .frame_count(fc[2]));

  vga_timing_gen #(.H_VISIBLE(SHV), .H_FP(SHFP), .H_SYNC(SHSW), .H_BP(SHBP),
                   .V_VISIBLE(SVV), .V_FP(SVFP), .V_SYNC(SVSW), .V_BP(SVBP),
                   .SYNC_DELAY(3)) u_s3 (
    .vga_clk(vga_clk), .reset(reset), .DrawX(dx[3]), .DrawY(dy[3]), .blank(bl[3]),
    .hs(hsy[3]), .vs(vsy[3]), .line_start(ls[3]), .frame_start(fs[3]), .frame_count(fc[3]));

  for (genvar g = 0; g < 4; g++) begin : g_obs
    assign got[g] = {dx[g], dy[g], bl[g], hsy[g], vsy[g], ls[g], fs[g], fc[g]};
  end

  cfg_t  cfgs [4];
  string names[4];
  int    vectors    = 0;
  int    miscompares = 0;
  int    t          = 0;   // cycles since release; t=0 is the first post-release cycle
  bit    started    = 1'b0;

  // Reference: everything follows from elapsed pixel time t.
  function automatic obs_t model(input cfg_t c, input int tt, input bit rst);
    obs_t o;
    int ht, vt, hc, vc, td, hd, vd;
    o = '0;
    if (rst) begin
      o.hs = 1'b1;
      o.vs = 1'b1;
      return o;
    end
    ht = c.hv + c.hfp + c.hsw + c.hbp;
    vt = c.vv + c.vfp + c.vsw + c.vbp;
    hc = tt % ht;
    vc = (tt / ht) % vt;
    o.x     = 10'(hc);
    o.y     = 10'(vc);
    o.blank = (hc < c.hv) && (vc < c.vv);
    o.ls    = (hc == 0);
    o.fs    = (hc == 0) && (vc == 0);
    o.fc    = 8'((tt / (ht * vt)) % 256);
    if (tt < c.d) begin
      o.hs = 1'b1;
      o.vs = 1'b1;
    end else begin
      td = tt - c.d;
      hd = td % ht;
      vd = (td / ht) % vt;
      o.hs = !((hd >= c.hv + c.hfp) && (hd < c.hv + c.hfp + c.hsw));
      o.vs = !((vd >= c.vv + c.vfp) && (vd < c.vv + c.vfp + c.vsw));
    end
    return o;
  endfunction

  function automatic obs_t mk(input int x, input int y, input bit b, input bit h,
                              input bit v, input bit l, input bit f, input int c);
    obs_t o;
    o.x = 10'(x); o.y = 10'(y); o.blank = b; o.hs = h; o.vs = v;
    o.ls = l; o.fs = f; o.fc = 8'(c);
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0d got=%0h want=%0h", name, t, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
    if (!reset) begin
      if (started) t++;
      else begin
        t = 0;
        started = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) check(names[i], got[i], model(cfgs[i], t, reset));
  endtask

  task automatic assert_reset();
    #($urandom_range(1, 3));
    reset   = 1'b1;
    started = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) check("async_rst", got[i], model(cfgs[i], 0, 1'b1));
  endtask

  task automatic release_reset();
    @(negedge vga_clk);
    reset = 1'b0;
  endtask

  vec_t tbl[14];

  initial begin
    int bcnt, hcnt, first_lo[4], found;

    cfgs[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1};
    cfgs[1] = '{SHV, SHFP, SHSW, SHBP, SVV, SVFP, SVSW, SVBP, 1};
    cfgs[2] = '{SHV, SHFP, SHSW, SHBP, SVV, SVFP, SVSW, SVBP, 0};
    cfgs[3] = '{SHV, SHFP, SHSW, SHBP, SVV, SVFP, SVSW, SVBP, 3};
    names[0] = "def_d1"; names[1] = "sml_d1"; names[2] = "sml_d0"; names[3] = "sml_d3";

    // Hand-derived points on the small raster, SYNC_DELAY=1.
    //                      x   y  blk hs vs ls fs fc
    tbl[0]  = '{0,   mk( 0, 0, 1, 1, 1, 1, 1, 0)};
    tbl[1]  = '{7,   mk( 7, 0, 1, 1, 1, 0, 0, 0)};
    tbl[2]  = '{8,   mk( 8, 0, 0, 1, 1, 0, 0, 0)};
    tbl[3]  = '{10,  mk(10, 0, 0, 1, 1, 0, 0, 0)};
    tbl[4]  = '{11,  mk(11, 0, 0, 0, 1, 0, 0, 0)};
    tbl[5]  = '{13,  mk(13, 0, 0, 0, 1, 0, 0, 0)};
    tbl[6]  = '{14,  mk(14, 0, 0, 1, 1, 0, 0, 0)};
    tbl[7]  = '{15,  mk( 0, 1, 1, 1, 1, 1, 0, 0)};
    tbl[8]  = '{75,  mk( 0, 5, 0, 1, 1, 1, 0, 0)};
    tbl[9]  = '{90,  mk( 0, 6, 0, 1, 1, 1, 0, 0)};
    tbl[10] = '{91,  mk( 1, 6, 0, 1, 0, 0, 0, 0)};
    tbl[11] = '{121, mk( 1, 8, 0, 1, 1, 0, 0, 0)};
    tbl[12] = '{135, mk( 0, 0, 1, 1, 1, 1, 1, 1)};
    tbl[13] = '{136, mk( 1, 0, 1, 1, 1, 0, 0, 1)};

    // Reset held 10 cycles, then the table.
    for (int i = 0; i < 10; i++) tick();
    release_reset();
    for (int k = 0; k < 14; k++) begin
      while (!started || t < tbl[k].t) tick();
      check("tbl", got[1], tbl[k].e);
    end

    // One full-size line plus sync-edge placement for each delay.
    assert_reset();
    tick(); tick();
    release_reset();
    bcnt = 0; hcnt = 0;
    for (int i = 0; i < 4; i++) first_lo[i] = -1;
    for (int n = 0; n < 800; n++) begin
      tick();
      if (bl[0]) bcnt++;
      if (!hsy[0]) hcnt++;
      for (int i = 0; i < 4; i++) if (!hsy[i] && first_lo[i] < 0) first_lo[i] = t;
    end
    check("line_blank_cnt", 64'(bcnt), 64'd640);
    check("line_hs_low_cnt", 64'(hcnt), 64'd96);
    check("hs_fall_def_d1", 64'(first_lo[0]), 64'd657);
    check("hs_fall_sml_d1", 64'(first_lo[1]), 64'd11);
    check("hs_fall_sml_d0", 64'(first_lo[2]), 64'd10);
    check("hs_fall_sml_d3", 64'(first_lo[3]), 64'd13);

    // Reset in the middle of both sync pulses.
    found = 0;
    for (int n = 0; n < 500 && found == 0; n++) begin
      tick();
      if (dx[1] == 10'd11 && dy[1] == 10'd6) found = 1;
    end
    check("midrst_found", 64'(found), 64'd1);
    check("midrst_pre_hs", 64'(hsy[1]), 64'd0);
    check("midrst_pre_vs", 64'(vsy[1]), 64'd0);
    assert_reset();
    for (int i = 0; i < 3; i++) tick();
    release_reset();

    // Randomized run lengths and reset pulses.
    for (int r = 0; r < 20; r++) begin
      int run_len, hold;
      run_len = $urandom_range(1, 300);
      hold    = $urandom_range(1, 4);
      for (int n = 0; n < run_len; n++) tick();
      assert_reset();
      for (int n = 0; n < hold; n++) tick();
      release_reset();
    end

    // 256 frames: frame_count 255 -> 0 together with frame_start.
    while (!started || t < 256 * SFRAME + 1) begin
      tick();
      if (t == 256 * SFRAME - 1) check("fc_255", 64'(fc[1]), 64'd255);
      if (t == 256 * SFRAME) begin
        check("fc_wrap0", 64'(fc[1]), 64'd0);
        check("fs_at_wrap", 64'(fs[1]), 64'd1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0d got=running want=finished", t);
    $fatal(1, "watchdog expired");
  end

endmodule
